// File: rtl/control_unit_pipe.sv
// Registered ID-stage decoder: one-cycle ID/EX control bundle, load-use stall,
// control-transfer flush and a halt sequencer that drains the pipe then freezes fetch.
module control_unit_pipe #(
    parameter int N_BITS       = 32,
    parameter int N_BITS_OP    = 6,
    parameter int N_BITS_FUNC  = 6,
    parameter int N_BITS_REG   = 5,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic [N_BITS-1:0]    i_instruccion,
    output logic                 o_stall,
    output logic                 o_flush,
    output logic                 o_halted,
    output logic [1:0]           o_ex_alu_op,
    output logic                 o_ex_alu_src,
    output logic                 o_ex_reg_dst,
    output logic                 o_ex_branch,
    output logic                 o_ex_branch_ne,
    output logic                 o_ex_mem_read,
    output logic                 o_ex_mem_write,
    output logic                 o_ex_mem_to_reg,
    output logic                 o_ex_reg_write,
    output logic [1:0]           o_ex_jump,
    output logic                 o_ex_link,
    output logic [N_BITS_OP-1:0] o_ex_opcode,
    output logic                 o_illegal
);
    // state   | meaning
    // RUN     | normal decode, hazard and flush active
    // DRAIN   | HALT accepted, bubbles while older instructions retire
    // HALTED  | pipe empty, fetch frozen until reset
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    typedef struct packed {
        logic [1:0]           alu_op;
        logic                 alu_src;
        logic                 reg_dst;
        logic                 branch;
        logic                 branch_ne;
        logic                 mem_read;
        logic                 mem_write;
        logic                 mem_to_reg;
        logic                 reg_write;
        logic [1:0]           jump;
        logic                 link;
        logic [N_BITS_OP-1:0] opcode;
    } bundle_t;

    localparam logic [3:0] CNT_LOAD = 4'(DRAIN_CYCLES - 1);

    logic [5:0]             opcode;
    logic [N_BITS_FUNC-1:0] funct;
    logic [N_BITS_REG-1:0]  rs, rt, ex_rt;
    logic                   unused_bits;
    assign opcode      = i_instruccion[31:26];
    assign funct       = i_instruccion[N_BITS_FUNC-1:0];
    assign rs          = i_instruccion[25:21];
    assign rt          = i_instruccion[20:16];
    assign unused_bits = ^i_instruccion[15:6];

    bundle_t dec, bun_nxt, ex_q;
    logic    dec_illegal, dec_halt, uses_rt, hazard, ill_nxt;
    state_t  state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        dec_halt    = 1'b0;
        uses_rt     = 1'b0;
        case (opcode)
            6'b000000: begin
                uses_rt = 1'b1;
                case (funct)
                    6'b001000: dec.jump = 2'b11;
                    6'b001001: begin
                        dec.jump      = 2'b10;
                        dec.reg_dst   = 1'b1;
                        dec.reg_write = 1'b1;
                        dec.link      = 1'b1;
                    end
                    default: begin
                        dec.alu_op    = 2'b10;
                        dec.reg_dst   = 1'b1;
                        dec.reg_write = 1'b1;
                        dec.opcode    = N_BITS_OP'(funct);
                    end
                endcase
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b001111: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b10;
                // immediate ops reuse the ALU function code of their R-type twin
                case (opcode)
                    6'b001100: dec.opcode = N_BITS_OP'(6'b100100);
                    6'b001101: dec.opcode = N_BITS_OP'(6'b100101);
                    6'b001110: dec.opcode = N_BITS_OP'(6'b100110);
                    6'b001010: dec.opcode = N_BITS_OP'(6'b101010);
                    6'b001111: dec.opcode = N_BITS_OP'(6'b001111);
                    default:   dec.opcode = N_BITS_OP'(6'b001000);
                endcase
            end
            6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100111: begin
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.opcode     = N_BITS_OP'(opcode);
            end
            6'b101000, 6'b101001, 6'b101011: begin
                uses_rt       = 1'b1;
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            6'b000100, 6'b000101: begin
                uses_rt       = 1'b1;
                dec.branch    = 1'b1;
                dec.alu_op    = 2'b01;
                dec.branch_ne = opcode[0];
            end
            6'b000010: dec.jump = 2'b01;
            6'b000011: begin
                dec.jump      = 2'b01;
                dec.link      = 1'b1;
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
            end
            6'b111111: dec_halt = 1'b1;
            default:   dec_illegal = 1'b1;
        endcase
    end

    assign hazard = i_valid && (state == RUN) && ex_q.mem_read && (ex_rt != '0)
                    && ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bun_nxt   = '0;
        ill_nxt   = 1'b0;
        o_stall   = 1'b0;
        o_flush   = 1'b0;
        case (state)
            RUN: begin
                if (hazard) begin
                    o_stall = 1'b1;
                end else if (i_valid) begin
                    if (dec_halt) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = CNT_LOAD;
                    end else begin
                        bun_nxt = dec;
                        ill_nxt = dec_illegal;
                        o_flush = (dec.jump != 2'b00);
                    end
                end
            end
            DRAIN: begin
                o_stall = 1'b1;
                if (cnt == 4'd0) state_nxt = HALTED;
                else             cnt_nxt   = cnt - 4'd1;
            end
            HALTED:  o_stall = 1'b1;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= RUN;
            cnt       <= '0;
            ex_q      <= '0;
            ex_rt     <= '0;
            o_illegal <= 1'b0;
            o_halted  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ex_q      <= bun_nxt;
            ex_rt     <= (bun_nxt != '0) ? rt : '0;
            o_illegal <= ill_nxt;
            o_halted  <= (state_nxt == HALTED);
        end
    end

    assign o_ex_alu_op     = ex_q.alu_op;
    assign o_ex_alu_src    = ex_q.alu_src;
    assign o_ex_reg_dst    = ex_q.reg_dst;
    assign o_ex_branch     = ex_q.branch;
    assign o_ex_branch_ne  = ex_q.branch_ne;
    assign o_ex_mem_read   = ex_q.mem_read;
    assign o_ex_mem_write  = ex_q.mem_write;
    assign o_ex_mem_to_reg = ex_q.mem_to_reg;
    assign o_ex_reg_write  = ex_q.reg_write;
    assign o_ex_jump       = ex_q.jump;
    assign o_ex_link       = ex_q.link;
    assign o_ex_opcode     = ex_q.opcode;
endmodule

// File: tb/tb_control_unit_pipe.sv
// Directed vector bench for control_unit_pipe: decode table, load-use stall,
// flush, illegal pulse, halt drain timing and reset out of DRAIN/HALTED.
module tb_control_unit_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] instr;
    logic        stall, flush, halted, illegal;
    logic [1:0]  alu_op, jump;
    logic        alu_src, reg_dst, branch, branch_ne, mem_read, mem_write, mem_to_reg, reg_write, link;
    logic [5:0]  opc;
    logic [18:0] act_bun;

    int checks = 0;
    int errors = 0;

    control_unit_pipe dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_instruccion(instr),
        .o_stall(stall), .o_flush(flush), .o_halted(halted),
        .o_ex_alu_op(alu_op), .o_ex_alu_src(alu_src), .o_ex_reg_dst(reg_dst),
        .o_ex_branch(branch), .o_ex_branch_ne(branch_ne), .o_ex_mem_read(mem_read),
        .o_ex_mem_write(mem_write), .o_ex_mem_to_reg(mem_to_reg), .o_ex_reg_write(reg_write),
        .o_ex_jump(jump), .o_ex_link(link), .o_ex_opcode(opc), .o_illegal(illegal)
    );

    always #5 clk = ~clk;

    assign act_bun = {alu_op, alu_src, reg_dst, branch, branch_ne, mem_read, mem_write,
                      mem_to_reg, reg_write, jump, link, opc};

    function automatic logic [18:0] bun(input logic [1:0] aop, input logic src, input logic dst,
                                        input logic br, input logic bne, input logic mr,
                                        input logic mw, input logic m2r, input logic rw,
                                        input logic [1:0] jmp, input logic lnk, input logic [5:0] op);
        return {aop, src, dst, br, bne, mr, mw, m2r, rw, jmp, lnk, op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // comb outputs checked before the edge, registered outputs #1 after it
    task automatic step(input string nm, input logic v, input logic [31:0] ins,
                        input logic es, input logic ef, input logic [18:0] eb,
                        input logic eill, input logic eh);
        @(negedge clk);
        valid = v;
        instr = ins;
        #1;
        chk({nm, "_stall"}, 32'(stall), 32'(es));
        chk({nm, "_flush"}, 32'(flush), 32'(ef));
        @(posedge clk);
        #1;
        chk({nm, "_bundle"}, 32'(act_bun), 32'(eb));
        chk({nm, "_illegal"}, 32'(illegal), 32'(eill));
        chk({nm, "_halted"}, 32'(halted), 32'(eh));
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, "_stall"}, 32'(stall), 32'd0);
        chk({nm, "_flush"}, 32'(flush), 32'd0);
        chk({nm, "_bundle"}, 32'(act_bun), 32'd0);
        chk({nm, "_illegal"}, 32'(illegal), 32'd0);
        chk({nm, "_halted"}, 32'(halted), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic        stall;
        logic        flush;
        logic [18:0] bun;
        logic        ill;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    logic [18:0] B0, B_ADDI, B_LW, B_ADD, B_SW, B_ORI;
    localparam logic [31:0] I_ADD  = 32'h0044_1820;
    localparam logic [31:0] I_HALT = 32'hFD80_0000;
    localparam logic [31:0] I_ADDI = 32'h2001_0005;

    initial begin
        B0     = '0;
        B_ADDI = bun(2'b10, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 6'b001000);
        B_LW   = bun(2'b00, 1, 0, 0, 0, 1, 0, 1, 1, 2'b00, 0, 6'b100011);
        B_ADD  = bun(2'b10, 0, 1, 0, 0, 0, 0, 0, 1, 2'b00, 0, 6'b100000);
        B_SW   = bun(2'b00, 1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 6'b000000);
        B_ORI  = bun(2'b10, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 6'b100101);

        vecs[0]  = '{1, I_ADDI,       0, 0, B_ADDI, 0};
        vecs[1]  = '{1, 32'h8C22_0000, 0, 0, B_LW, 0};          // lw $2,0($1)
        vecs[2]  = '{1, I_ADD,        1, 0, B0, 0};             // add $3,$2,$4 stalls
        vecs[3]  = '{1, I_ADD,        0, 0, B_ADD, 0};
        vecs[4]  = '{1, 32'h8C20_0000, 0, 0, B_LW, 0};          // lw $0,0($1)
        vecs[5]  = '{1, 32'h0004_1820, 0, 0, B_ADD, 0};         // add $3,$0,$4 no stall
        vecs[6]  = '{1, 32'h3405_0007, 0, 0, B_ORI, 0};         // ori $5,$0,7
        vecs[7]  = '{1, 32'h8CA6_0000, 0, 0, B_LW, 0};          // lw $6,0($5)
        vecs[8]  = '{1, 32'hACE6_0004, 1, 0, B0, 0};            // sw $6 uses rt -> stall
        vecs[9]  = '{1, 32'hACE6_0004, 0, 0, B_SW, 0};
        vecs[10] = '{1, 32'h8C08_0000, 0, 0, B_LW, 0};          // lw $8,0($0)
        vecs[11] = '{1, 32'h2128_0001, 0, 0, B_ADDI, 0};        // addi $8,$9: rt not a source
        vecs[12] = '{1, 32'h00A0_F809, 0, 1, bun(2'b00, 0, 1, 0, 0, 0, 0, 0, 1, 2'b10, 1, 6'd0), 0};
        vecs[13] = '{1, 32'h1022_0003, 0, 0, bun(2'b01, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 6'd0), 0};
        vecs[14] = '{1, 32'h1422_0003, 0, 0, bun(2'b01, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 6'd0), 0};
        vecs[15] = '{1, 32'h0800_0010, 0, 1, bun(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 6'd0), 0};
        vecs[16] = '{1, 32'h0C00_0010, 0, 1, bun(2'b00, 0, 1, 0, 0, 0, 0, 0, 1, 2'b01, 1, 6'd0), 0};
        vecs[17] = '{1, 32'h03E0_0008, 0, 1, bun(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 6'd0), 0};
        vecs[18] = '{0, 32'h03E0_0008, 0, 0, B0, 0};            // invalid slot
        vecs[19] = '{1, 32'hF800_0000, 0, 0, B0, 1};            // opcode 111110
        vecs[20] = '{1, I_ADD,        0, 0, B_ADD, 0};
        vecs[21] = '{1, 32'h3C0A_1234, 0, 0, bun(2'b10, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 6'b001111), 0};
        vecs[22] = '{1, 32'hA000_0000, 0, 0, B_SW, 0};          // sb
        vecs[23] = '{1, 32'h800B_0000, 0, 0, bun(2'b00, 1, 0, 0, 0, 1, 0, 1, 1, 2'b00, 0, 6'b100000), 0};

        rst   = 1'b1;
        valid = 1'b0;
        instr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_bundle", 32'(act_bun), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++)
            step($sformatf("v%0d", i), vecs[i].v, vecs[i].ins, vecs[i].stall,
                 vecs[i].flush, vecs[i].bun, vecs[i].ill, 1'b0);

        // HALT blocked by load-use, then drains DRAIN_CYCLES=4 cycles and freezes
        step("hz_lw",   1, 32'h8C0C_0000, 0, 0, B_LW, 0, 0);
        step("hz_halt", 1, I_HALT, 1, 0, B0, 0, 0);
        step("halt_go", 1, I_HALT, 0, 0, B0, 0, 0);
        step("drain1",  1, 32'h03E0_0008, 1, 0, B0, 0, 0);
        step("drain2",  1, I_ADD, 1, 0, B0, 0, 0);
        step("drain3",  1, I_ADD, 1, 0, B0, 0, 0);
        step("drain4",  1, I_ADD, 1, 0, B0, 0, 1);
        step("halted1", 1, I_ADD, 1, 0, B0, 0, 1);
        step("halted2", 1, 32'hF800_0000, 1, 0, B0, 0, 1);
        do_reset("rst_halted");
        step("post_rst1", 1, I_ADDI, 0, 0, B_ADDI, 0, 0);

        // reset in the middle of DRAIN
        step("halt2_go", 1, I_HALT, 0, 0, B0, 0, 0);
        step("d2_1",     1, I_ADD, 1, 0, B0, 0, 0);
        step("d2_2",     1, I_ADD, 1, 0, B0, 0, 0);
        do_reset("rst_drain");
        step("post_rst2", 1, I_ADD, 0, 0, B_ADD, 0, 0);
        step("post_rst3", 1, 32'h03E0_0008, 0, 1, bun(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 6'd0), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary line");
        $fatal(1);
    end
endmodule
